id_hazard_scheduler: RTL and testbench
======================================

Name: id_hazard_scheduler

Overview:
- Hazard and forwarding scheduler for the 5-stage pipeline (F/D/E/M/W).
- Keeps its own scoreboard of in-flight destination registers and their remaining Tnew for the E and M stages.
- Drives the ID-stage forwarding selects (0 = GRF, 1 = EXBack, 2 = MEMBack) and a global stall.
- Sequences the multi-cycle mult/div unit with a busy counter, so D-stage HI/LO users and new mult/div instructions wait.

Parameters:
- MULT_CYCLES, 5, busy cycles loaded for mult/multu (1..15).
- DIV_CYCLES, 10, busy cycles loaded for div/divu (1..15).

Ports:
- clk  input  1  pipeline clock.
- reset  input  1  asynchronous, active-low reset.
- d_rs  input  5  rs field of the instruction in D.
- d_rt  input  5  rt field of the instruction in D.
- d_tuse_rs  input  2  cycles until D needs rs (0 = needed in D, e.g. branch/jr; 3 = not read).
- d_tuse_rt  input  2  same for rt.
- d_dst  input  5  destination register (regA3) of the D instruction; 0 = no write.
- d_tnew  input  2  Tnew of the D instruction as it enters E (0 = result at EXBack in E).
- d_md_op  input  2  0 none, 1 mult-class, 2 div-class, 3 reserved (treated as none).
- d_md_use  input  1  D instruction reads or writes HI/LO (mfhi/mflo/mthi/mtlo).
- flush  input  1  synchronous: loads bubbles into the E and M scoreboard entries.
- stall  output  1  freeze PC and the F/D register, insert a bubble into E.
- fwd_rs  output  2  regRD1Forward select.
- fwd_rt  output  2  regRD2Forward select.
- md_busy  output  1  mult/div unit is occupied.

Behaviour:
Reset (reset=0, asynchronous):
- e_dst, e_tnew, m_dst, m_tnew and md_cnt are all cleared to 0.
- Outputs: stall=0, fwd_rs=0, fwd_rt=0, md_busy=0.

Scoreboard update (each posedge clk):
- M entry <= E entry, with m_tnew = max(e_tnew-1, 0).
- E entry <= {d_dst, d_tnew} if stall=0; otherwise E gets a bubble {0,0}.
- If flush=1, both E and M entries get bubbles. flush has priority over everything else.

Data stall (combinational), for each source s in {rs, rt} with s != 0:
- stall if e_dst == s and e_tnew > tuse_s.
- stall if m_dst == s and m_tnew > tuse_s.
- A register value of 0 never stalls and never forwards.
- W-stage hazards are covered by GRF write-through; no W forwarding path and no W stall exist here.

Forward select (combinational):
- fwd = 1 if e_dst == s, s != 0 and e_tnew == 0.
- Else fwd = 2 if m_dst == s, s != 0 and m_tnew == 0.
- Else fwd = 0.
- E has priority over M (youngest producer wins).
- Encoding 3 is never driven.

Mult/div scheduling:
- md_busy = (md_cnt != 0).
- Stall if (d_md_op is 1 or 2, or d_md_use=1) and md_busy=1.
- When a D instruction with d_md_op = 1 or 2 advances (stall=0, flush=0), md_cnt loads MULT_CYCLES or DIV_CYCLES at that edge.
- Otherwise md_cnt decrements by 1 when nonzero.
- md_cnt is 4 bits wide. It is not cleared by flush: the operation already issued completes.

Final output:
- stall = data stall OR mult/div stall.
- Both are evaluated in the same cycle; there is no priority between them.

Test Plan:
- Load-use: lw $8 in E (e_dst=8, e_tnew=2), D add with rs=8, tuse_rs=1 -> stall=1 for 1 cycle. Next cycle M has m_tnew=1 and no stall. The cycle after, the producer is in W, fwd_rs=0 (GRF) and stall=0.
- Branch on ALU result: addu $5 in E (e_tnew=1), D beq rs=5, tuse=0 -> stall=1. Next cycle m_dst=5, m_tnew=0, giving fwd_rs=2 and stall=0.
- jal then jr $31: E entry {31, 0}, D jr rs=31, tuse=0 -> fwd_rs=1, stall=0. A D instruction with rs=0 and e_dst=0 -> fwd_rs=0, stall=0.
- Both stages write $9 with tnew=0 -> fwd_rt=1 (E priority). Remove the E match -> fwd_rt=2.
- mult advances, then mflo in D -> stall=1 for exactly MULT_CYCLES=5 cycles; md_busy falls on the 5th edge. A div with DIV_CYCLES=10 gives a 10-cycle stall.
- Assert reset low mid-div (md_cnt=6) and mid-stall -> all outputs 0 immediately, without waiting for a clock edge. flush with a hazard pending -> stall=0 on the next cycle.

Source files
------------

// File: rtl/id_hazard_scheduler.sv
// ID-stage hazard scheduler: tracks E/M destination registers with their remaining
// Tnew, derives the stall and GRF/EXBack/MEMBack forwarding selects, and gates mult/div.
module id_hazard_scheduler #(
  parameter int unsigned MULT_CYCLES = 5,
  parameter int unsigned DIV_CYCLES  = 10
) (
  input  logic       clk,
  input  logic       reset,
  input  logic [4:0] d_rs,
  input  logic [4:0] d_rt,
  input  logic [1:0] d_tuse_rs,
  input  logic [1:0] d_tuse_rt,
  input  logic [4:0] d_dst,
  input  logic [1:0] d_tnew,
  input  logic [1:0] d_md_op,
  input  logic       d_md_use,
  input  logic       flush,
  output logic       stall,
  output logic [1:0] fwd_rs,
  output logic [1:0] fwd_rt,
  output logic       md_busy
);

  localparam logic [3:0] MULT_LOAD = 4'(MULT_CYCLES);
  localparam logic [3:0] DIV_LOAD  = 4'(DIV_CYCLES);

  logic [4:0] e_dst_q, e_dst_d;
  logic [1:0] e_tnew_q, e_tnew_d;
  logic [4:0] m_dst_q, m_dst_d;
  logic [1:0] m_tnew_q, m_tnew_d;
  logic [3:0] md_cnt_q, md_cnt_d;

  logic data_stall;
  logic md_stall;
  logic md_issue;
  logic md_class;

  function automatic logic src_hazard(
    input logic [4:0] src,
    input logic [1:0] tuse,
    input logic [4:0] e_dst,
    input logic [1:0] e_tnew,
    input logic [4:0] m_dst,
    input logic [1:0] m_tnew
  );
    logic hz;
    hz = 1'b0;
    if (src != 5'd0) begin
      if ((e_dst == src) && (e_tnew > tuse)) hz = 1'b1;
      if ((m_dst == src) && (m_tnew > tuse)) hz = 1'b1;
    end
    return hz;
  endfunction

  // E is checked first so the youngest producer wins when both stages match.
  function automatic logic [1:0] fwd_sel(
    input logic [4:0] src,
    input logic [4:0] e_dst,
    input logic [1:0] e_tnew,
    input logic [4:0] m_dst,
    input logic [1:0] m_tnew
  );
    logic [1:0] sel;
    sel = 2'd0;
    if (src != 5'd0) begin
      if ((e_dst == src) && (e_tnew == 2'd0))      sel = 2'd1;
      else if ((m_dst == src) && (m_tnew == 2'd0)) sel = 2'd2;
    end
    return sel;
  endfunction

  always_comb begin
    md_class   = (d_md_op == 2'd1) || (d_md_op == 2'd2);
    md_busy    = (md_cnt_q != 4'd0);
    md_stall   = (md_class || d_md_use) && md_busy;
    data_stall = src_hazard(d_rs, d_tuse_rs, e_dst_q, e_tnew_q, m_dst_q, m_tnew_q) ||
                 src_hazard(d_rt, d_tuse_rt, e_dst_q, e_tnew_q, m_dst_q, m_tnew_q);
    stall      = data_stall || md_stall;
    fwd_rs     = fwd_sel(d_rs, e_dst_q, e_tnew_q, m_dst_q, m_tnew_q);
    fwd_rt     = fwd_sel(d_rt, e_dst_q, e_tnew_q, m_dst_q, m_tnew_q);
    md_issue   = md_class && !stall && !flush;
  end

  always_comb begin
    e_dst_d  = '0;
    e_tnew_d = '0;
    m_dst_d  = '0;
    m_tnew_d = '0;
    if (!flush) begin
      m_dst_d  = e_dst_q;
      m_tnew_d = (e_tnew_q == 2'd0) ? 2'd0 : e_tnew_q - 2'd1;
      if (!stall) begin
        e_dst_d  = d_dst;
        e_tnew_d = d_tnew;
      end
    end
  end

  // Flush deliberately leaves the counter alone: an issued mult/div always completes.
  always_comb begin
    md_cnt_d = md_cnt_q;
    if (md_issue)              md_cnt_d = (d_md_op == 2'd1) ? MULT_LOAD : DIV_LOAD;
    else if (md_cnt_q != 4'd0) md_cnt_d = md_cnt_q - 4'd1;
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      e_dst_q  <= '0;
      e_tnew_q <= '0;
      m_dst_q  <= '0;
      m_tnew_q <= '0;
      md_cnt_q <= '0;
    end else begin
      e_dst_q  <= e_dst_d;
      e_tnew_q <= e_tnew_d;
      m_dst_q  <= m_dst_d;
      m_tnew_q <= m_tnew_d;
      md_cnt_q <= md_cnt_d;
    end
  end

endmodule

// File: tb/tb_id_hazard_scheduler.sv
// Bench for id_hazard_scheduler: producers are modelled by the absolute cycle their
// result becomes available, and mult/div by the cycle the unit becomes free.
module tb_id_hazard_scheduler;

  localparam int MULT = 5;
  localparam int DIV  = 10;

  logic       clk;
  logic       reset;
  logic [4:0] d_rs, d_rt, d_dst;
  logic [1:0] d_tuse_rs, d_tuse_rt, d_tnew, d_md_op;
  logic       d_md_use, flush;
  logic       stall, md_busy;
  logic [1:0] fwd_rs, fwd_rt;

  int n_checks = 0;
  int n_err    = 0;

  id_hazard_scheduler #(.MULT_CYCLES(MULT), .DIV_CYCLES(DIV)) dut (
    .clk(clk), .reset(reset),
    .d_rs(d_rs), .d_rt(d_rt), .d_tuse_rs(d_tuse_rs), .d_tuse_rt(d_tuse_rt),
    .d_dst(d_dst), .d_tnew(d_tnew), .d_md_op(d_md_op), .d_md_use(d_md_use),
    .flush(flush), .stall(stall), .fwd_rs(fwd_rs), .fwd_rt(fwd_rt), .md_busy(md_busy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    int dst;
    int ready;
    int enter;
  } rec_t;

  rec_t q[$];
  int   cyc     = 0;
  int   md_free = 0;
  bit   mst;

  function automatic int remaining(input int idx);
    int r;
    r = q[idx].ready - cyc;
    return (r < 0) ? 0 : r;
  endfunction

  function automatic bit model_stall();
    bit s;
    s = 1'b0;
    foreach (q[i]) begin
      if (d_rs != 5'd0 && q[i].dst == int'(d_rs) && remaining(i) > int'(d_tuse_rs)) s = 1'b1;
      if (d_rt != 5'd0 && q[i].dst == int'(d_rt) && remaining(i) > int'(d_tuse_rt)) s = 1'b1;
    end
    if ((d_md_op == 2'd1 || d_md_op == 2'd2 || d_md_use) && cyc < md_free) s = 1'b1;
    return s;
  endfunction

  function automatic int model_fwd(input int src);
    int res;
    res = 0;
    if (src == 0) return 0;
    foreach (q[i]) begin
      if (q[i].dst == src && remaining(i) == 0) begin
        if (q[i].enter == cyc) return 1;
        res = 2;
      end
    end
    return res;
  endfunction

  always @(posedge clk or negedge reset) begin
    if (!reset) begin
      q.delete();
      md_free = 0;
      cyc     = 0;
    end else begin
      mst = model_stall();
      if (flush) q.delete();
      else if (!mst && d_dst != 5'd0)
        q.push_back('{int'(d_dst), cyc + 1 + int'(d_tnew), cyc + 1});
      if (!flush && !mst && (d_md_op == 2'd1 || d_md_op == 2'd2))
        md_free = cyc + 1 + ((d_md_op == 2'd1) ? MULT : DIV);
      cyc++;
      for (int i = q.size() - 1; i >= 0; i--)
        if (q[i].enter < cyc - 1) q.delete(i);
    end
  end

  task automatic chk(input string name, input int act, input int exp);
    n_checks++;
    if (act != exp) begin
      n_err++;
      $display("FAIL %s: got %0d expected %0d (t=%0t)", name, act, exp, $time);
    end
  endtask

  always @(negedge clk) begin
    chk("model_stall",   int'(stall),   int'(model_stall()));
    chk("model_fwd_rs",  int'(fwd_rs),  model_fwd(int'(d_rs)));
    chk("model_fwd_rt",  int'(fwd_rt),  model_fwd(int'(d_rt)));
    chk("model_md_busy", int'(md_busy), (cyc < md_free) ? 1 : 0);
  end

  task automatic drive(input logic [4:0] rs, input logic [1:0] tur,
                       input logic [4:0] rt, input logic [1:0] tut,
                       input logic [4:0] dst, input logic [1:0] tn,
                       input logic [1:0] op, input logic use_);
    d_rs = rs; d_tuse_rs = tur; d_rt = rt; d_tuse_rt = tut;
    d_dst = dst; d_tnew = tn; d_md_op = op; d_md_use = use_;
  endtask

  task automatic idle();
    drive(5'd0, 2'd3, 5'd0, 2'd3, 5'd0, 2'd0, 2'd0, 1'b0);
    flush = 1'b0;
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    reset = 1'b0;
    idle();
    repeat (2) @(posedge clk);
    #2;
    chk("reset_stall", int'(stall), 0);
    chk("reset_fwd_rs", int'(fwd_rs), 0);
    chk("reset_fwd_rt", int'(fwd_rt), 0);
    chk("reset_md_busy", int'(md_busy), 0);
    reset = 1'b1;
    tick();

    // load-use: lw $8 then add reading $8 in E
    drive(5'd0, 2'd3, 5'd0, 2'd3, 5'd8, 2'd2, 2'd0, 1'b0);
    tick();
    drive(5'd8, 2'd1, 5'd0, 2'd3, 5'd10, 2'd1, 2'd0, 1'b0);
    #1 chk("lu_stall", int'(stall), 1);
    tick();
    #1 chk("lu_m_stall", int'(stall), 0);
    chk("lu_m_fwd", int'(fwd_rs), 0);
    tick();
    #1 chk("lu_w_stall", int'(stall), 0);
    chk("lu_w_fwd", int'(fwd_rs), 0);
    idle();
    repeat (2) tick();

    // branch on an ALU result
    drive(5'd0, 2'd3, 5'd0, 2'd3, 5'd5, 2'd1, 2'd0, 1'b0);
    tick();
    drive(5'd5, 2'd0, 5'd0, 2'd3, 5'd0, 2'd0, 2'd0, 1'b0);
    #1 chk("br_stall", int'(stall), 1);
    tick();
    #1 chk("br_fwd_mem", int'(fwd_rs), 2);
    chk("br_nostall", int'(stall), 0);
    idle();
    repeat (2) tick();

    // jal then jr $31; $0 never forwards
    drive(5'd0, 2'd3, 5'd0, 2'd3, 5'd31, 2'd0, 2'd0, 1'b0);
    tick();
    drive(5'd31, 2'd0, 5'd0, 2'd3, 5'd0, 2'd0, 2'd0, 1'b0);
    #1 chk("jr_fwd_ex", int'(fwd_rs), 1);
    chk("jr_stall", int'(stall), 0);
    drive(5'd0, 2'd0, 5'd0, 2'd0, 5'd0, 2'd0, 2'd0, 1'b0);
    #1 chk("r0_fwd", int'(fwd_rs), 0);
    chk("r0_stall", int'(stall), 0);
    idle();
    repeat (2) tick();

    // two writers of $9: E wins, then only M matches
    drive(5'd0, 2'd3, 5'd0, 2'd3, 5'd9, 2'd0, 2'd0, 1'b0);
    tick();
    tick();
    drive(5'd0, 2'd3, 5'd9, 2'd1, 5'd0, 2'd0, 2'd0, 1'b0);
    #1 chk("prio_fwd_ex", int'(fwd_rt), 1);
    tick();
    #1 chk("prio_fwd_mem", int'(fwd_rt), 2);
    idle();
    repeat (2) tick();

    // mult then mflo; a flush mid-wait must not shorten it
    drive(5'd0, 2'd3, 5'd0, 2'd3, 5'd0, 2'd0, 2'd1, 1'b0);
    tick();
    #1 chk("mult_busy", int'(md_busy), 1);
    drive(5'd0, 2'd3, 5'd0, 2'd3, 5'd2, 2'd0, 2'd0, 1'b1);
    for (int i = 0; i < MULT; i++) begin
      chk("mult_wait_stall", int'(stall), 1);
      flush = (i == 2);
      tick();
      flush = 1'b0;
    end
    chk("mult_done_stall", int'(stall), 0);
    chk("mult_done_busy", int'(md_busy), 0);
    tick();
    drive(5'd0, 2'd3, 5'd0, 2'd3, 5'd0, 2'd0, 2'd3, 1'b0);
    tick();
    #1 chk("op3_not_busy", int'(md_busy), 0);
    idle();
    tick();

    // div then mflo
    drive(5'd0, 2'd3, 5'd0, 2'd3, 5'd0, 2'd0, 2'd2, 1'b0);
    tick();
    drive(5'd0, 2'd3, 5'd0, 2'd3, 5'd2, 2'd0, 2'd0, 1'b1);
    for (int i = 0; i < DIV; i++) begin
      chk("div_wait_stall", int'(stall), 1);
      tick();
    end
    chk("div_done_stall", int'(stall), 0);
    idle();
    repeat (2) tick();

    // asynchronous reset in the middle of a div wait
    drive(5'd0, 2'd3, 5'd0, 2'd3, 5'd0, 2'd0, 2'd2, 1'b0);
    tick();
    drive(5'd0, 2'd3, 5'd0, 2'd3, 5'd2, 2'd0, 2'd0, 1'b1);
    repeat (4) tick();
    chk("pre_rst_stall", int'(stall), 1);
    chk("pre_rst_busy", int'(md_busy), 1);
    #1 reset = 1'b0;
    #1 chk("arst_stall", int'(stall), 0);
    chk("arst_busy", int'(md_busy), 0);
    chk("arst_fwd_rs", int'(fwd_rs), 0);
    tick();
    reset = 1'b1;
    #1 chk("post_rst_stall", int'(stall), 0);
    idle();
    tick();

    // flush clears a pending load-use hazard
    drive(5'd0, 2'd3, 5'd0, 2'd3, 5'd8, 2'd2, 2'd0, 1'b0);
    tick();
    drive(5'd8, 2'd1, 5'd0, 2'd3, 5'd10, 2'd1, 2'd0, 1'b0);
    #1 chk("fl_pre_stall", int'(stall), 1);
    flush = 1'b1;
    tick();
    flush = 1'b0;
    #1 chk("fl_post_stall", int'(stall), 0);
    idle();
    repeat (3) tick();

    $display("Result: errors=%0d of %0d checks", n_err, n_checks);
    $finish;
  end

endmodule
